// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg
// Shared definitions for the JTAG TAP controller: TAP state encoding,
// instruction register width, opcodes and the Capture-IR pattern.
package jtag_tap_pkg;

    localparam int IR_LEN = 5;

    localparam logic [IR_LEN-1:0] OP_IDCODE = 5'b00010;
    localparam logic [IR_LEN-1:0] OP_REG1   = 5'b00100;
    localparam logic [IR_LEN-1:0] OP_REG2   = 5'b00101;
    localparam logic [IR_LEN-1:0] OP_REG3   = 5'b00110;
    localparam logic [IR_LEN-1:0] OP_BYPASS = 5'b11111;

    // Loaded into the IR shift register in Capture-IR; the 01 in the two
    // LSBs lets the host detect broken IR chains.
    localparam logic [IR_LEN-1:0] CAPTURE_IR = 5'b00001;

    typedef enum logic [3:0] {
        TAP_TLR      = 4'h0,
        TAP_RTI      = 4'h1,
        TAP_SEL_DR   = 4'h2,
        TAP_CAP_DR   = 4'h3,
        TAP_SHIFT_DR = 4'h4,
        TAP_EXIT1_DR = 4'h5,
        TAP_PAUSE_DR = 4'h6,
        TAP_EXIT2_DR = 4'h7,
        TAP_UPD_DR   = 4'h8,
        TAP_SEL_IR   = 4'h9,
        TAP_CAP_IR   = 4'hA,
        TAP_SHIFT_IR = 4'hB,
        TAP_EXIT1_IR = 4'hC,
        TAP_PAUSE_IR = 4'hD,
        TAP_EXIT2_IR = 4'hE,
        TAP_UPD_IR   = 4'hF
    } tap_state_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm
// 16-state IEEE 1149.1 TAP state machine clocked by TCK.
// Ports:
//   i_tck, i_rst_n   TCK and synchronous active-low reset
//   i_tms            TMS, sampled on rising TCK
//   o_next_tlr       next state is Test-Logic-Reset (IR reload)
//   o_capture_dr/o_shift_dr/o_update_dr   DR state decodes
//   o_capture_ir/o_shift_ir/o_update_ir   IR state decodes
//
// state    | meaning
// TLR      | test-logic-reset, IR forced to IDCODE
// RTI      | run-test/idle
// SEL_DR   | select DR scan
// CAP_DR   | capture selected data register
// SHIFT_DR | shift data register, TDI in / TDO out
// EXIT1_DR | leave shift, go to pause or update
// PAUSE_DR | hold DR contents
// EXIT2_DR | resume shift or go to update
// UPD_DR   | update data register
// SEL_IR   | select IR scan
// CAP_IR   | load IR shift register with capture pattern
// SHIFT_IR | shift IR shift register
// EXIT1_IR | leave shift, go to pause or update
// PAUSE_IR | hold IR shift contents
// EXIT2_IR | resume shift or go to update
// UPD_IR   | copy IR shift register into IR
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic i_tck,
    input  logic i_rst_n,
    input  logic i_tms,
    output logic o_next_tlr,
    output logic o_capture_dr,
    output logic o_shift_dr,
    output logic o_update_dr,
    output logic o_capture_ir,
    output logic o_shift_ir,
    output logic o_update_ir
);

    tap_state_e r_state;
    tap_state_e w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            TAP_TLR:      w_next = i_tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      w_next = i_tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   w_next = i_tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   w_next = i_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: w_next = i_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: w_next = i_tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: w_next = i_tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: w_next = i_tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   w_next = i_tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   w_next = i_tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   w_next = i_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: w_next = i_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: w_next = i_tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: w_next = i_tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: w_next = i_tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   w_next = i_tms ? TAP_SEL_DR   : TAP_RTI;
            default:      w_next = TAP_TLR;
        endcase
    end

    always_ff @(posedge i_tck) begin
        if (!i_rst_n) begin
            r_state <= TAP_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_next_tlr   = (w_next  == TAP_TLR);
    assign o_capture_dr = (r_state == TAP_CAP_DR);
    assign o_shift_dr   = (r_state == TAP_SHIFT_DR);
    assign o_update_dr  = (r_state == TAP_UPD_DR);
    assign o_capture_ir = (r_state == TAP_CAP_IR);
    assign o_shift_ir   = (r_state == TAP_SHIFT_IR);
    assign o_update_ir  = (r_state == TAP_UPD_IR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl
// JTAG TAP controller: 5-bit IR, internal IDCODE and BYPASS registers,
// decode of three external user data registers and the TDO mux.
// Ports:
//   tck_i, rst_ni       TCK and synchronous active-low reset
//   tms_i, td_i, td_o   JTAG pins; td_o registered on falling TCK
//   shift_dr_o, update_dr_o, capture_dr_o   DR state strobes
//   memory_sel_o, fifo_sel_o, confreg_sel_o  IR decodes for user registers
//   scan_in_o           TDI forwarded to the user registers
//   memory_out_i, fifo_out_i, confreg_out_i  user register serial outputs
module jtag_tap_ctrl
    import jtag_tap_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h249511C3
)
(
    input  logic tck_i,
    input  logic rst_ni,
    input  logic tms_i,
    input  logic td_i,
    output logic td_o,
    output logic shift_dr_o,
    output logic update_dr_o,
    output logic capture_dr_o,
    output logic memory_sel_o,
    output logic fifo_sel_o,
    output logic confreg_sel_o,
    output logic scan_in_o,
    input  logic memory_out_i,
    input  logic fifo_out_i,
    input  logic confreg_out_i
);

    logic [IR_LEN-1:0] r_ir;
    logic [IR_LEN-1:0] r_ir_sr;
    logic [31:0]       r_idcode_sr;
    logic              r_bypass;
    logic              r_tdo;

    logic w_next_tlr;
    logic w_capture_dr;
    logic w_shift_dr;
    logic w_update_dr;
    logic w_capture_ir;
    logic w_shift_ir;
    logic w_update_ir;
    logic w_sel_idcode;
    logic w_sel_mem;
    logic w_sel_fifo;
    logic w_sel_conf;
    logic w_sel_bypass;
    logic w_tdo_next;

    jtag_tap_fsm u_fsm (
        .i_tck        (tck_i),
        .i_rst_n      (rst_ni),
        .i_tms        (tms_i),
        .o_next_tlr   (w_next_tlr),
        .o_capture_dr (w_capture_dr),
        .o_shift_dr   (w_shift_dr),
        .o_update_dr  (w_update_dr),
        .o_capture_ir (w_capture_ir),
        .o_shift_ir   (w_shift_ir),
        .o_update_ir  (w_update_ir)
    );

    assign w_sel_idcode = (r_ir == OP_IDCODE);
    assign w_sel_mem    = (r_ir == OP_REG1);
    assign w_sel_fifo   = (r_ir == OP_REG2);
    assign w_sel_conf   = (r_ir == OP_REG3);
    // Any unrecognised opcode (not only OP_BYPASS) routes through bypass.
    assign w_sel_bypass = ~(w_sel_idcode | w_sel_mem | w_sel_fifo | w_sel_conf);

    always_ff @(posedge tck_i) begin
        if (!rst_ni) begin
            r_ir        <= OP_IDCODE;
            r_ir_sr     <= '0;
            r_idcode_sr <= IDCODE_VALUE;
            r_bypass    <= 1'b0;
        end else begin
            if (w_next_tlr) begin
                r_ir <= OP_IDCODE;
            end else if (w_update_ir) begin
                r_ir <= r_ir_sr;
            end

            if (w_capture_ir) begin
                r_ir_sr <= CAPTURE_IR;
            end else if (w_shift_ir) begin
                r_ir_sr <= {td_i, r_ir_sr[IR_LEN-1:1]};
            end

            if (w_sel_idcode && w_capture_dr) begin
                r_idcode_sr <= IDCODE_VALUE;
            end else if (w_sel_idcode && w_shift_dr) begin
                r_idcode_sr <= {td_i, r_idcode_sr[31:1]};
            end

            if (w_sel_bypass && w_capture_dr) begin
                r_bypass <= 1'b0;
            end else if (w_sel_bypass && w_shift_dr) begin
                r_bypass <= td_i;
            end
        end
    end

    always_comb begin
        w_tdo_next = 1'b0;
        if (w_shift_ir) begin
            w_tdo_next = r_ir_sr[0];
        end else if (w_shift_dr) begin
            if (w_sel_idcode)      w_tdo_next = r_idcode_sr[0];
            else if (w_sel_mem)    w_tdo_next = memory_out_i;
            else if (w_sel_fifo)   w_tdo_next = fifo_out_i;
            else if (w_sel_conf)   w_tdo_next = confreg_out_i;
            else                   w_tdo_next = r_bypass;
        end
    end

    // Falling-edge launch gives the host a full half period of setup
    // before it samples TDO at the next rising edge.
    always_ff @(negedge tck_i) begin
        if (!rst_ni) begin
            r_tdo <= 1'b0;
        end else begin
            r_tdo <= w_tdo_next;
        end
    end

    assign td_o          = r_tdo;
    assign shift_dr_o    = w_shift_dr;
    assign update_dr_o   = w_update_dr;
    assign capture_dr_o  = w_capture_dr;
    assign memory_sel_o  = w_sel_mem;
    assign fifo_sel_o    = w_sel_fifo;
    assign confreg_sel_o = w_sel_conf;
    assign scan_in_o     = td_i;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl
// Directed and randomized bench for jtag_tap_ctrl with bench-side user
// data registers and a transaction-level expectation model.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDV = 32'h249511C3;

    logic tck = 1'b0;
    logic rst_n = 1'b0;
    logic tms = 1'b1;
    logic tdi = 1'b0;
    logic td_o, shift_dr_o, update_dr_o, capture_dr_o;
    logic memory_sel_o, fifo_sel_o, confreg_sel_o, scan_in_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_cap, cnt_shift, cnt_upd, scan_bad;

    // bench-side user registers
    logic [9:0]  r_mem,  mem_cap  = '0;
    logic [10:0] r_fifo, fifo_cap = '0;
    logic [11:0] r_conf, conf_cap = '0;

    always #5 tck = ~tck;

    always @(posedge tck) begin
        if (capture_dr_o && memory_sel_o)      r_mem <= mem_cap;
        else if (shift_dr_o && memory_sel_o)   r_mem <= {scan_in_o, r_mem[9:1]};
        if (capture_dr_o && fifo_sel_o)        r_fifo <= fifo_cap;
        else if (shift_dr_o && fifo_sel_o)     r_fifo <= {scan_in_o, r_fifo[10:1]};
        if (capture_dr_o && confreg_sel_o)     r_conf <= conf_cap;
        else if (shift_dr_o && confreg_sel_o)  r_conf <= {scan_in_o, r_conf[11:1]};
    end

    jtag_tap_ctrl #(.IDCODE_VALUE(IDV)) dut (
        .tck_i         (tck),
        .rst_ni        (rst_n),
        .tms_i         (tms),
        .td_i          (tdi),
        .td_o          (td_o),
        .shift_dr_o    (shift_dr_o),
        .update_dr_o   (update_dr_o),
        .capture_dr_o  (capture_dr_o),
        .memory_sel_o  (memory_sel_o),
        .fifo_sel_o    (fifo_sel_o),
        .confreg_sel_o (confreg_sel_o),
        .scan_in_o     (scan_in_o),
        .memory_out_i  (r_mem[0]),
        .fifo_out_i    (r_fifo[0]),
        .confreg_out_i (r_conf[0])
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    // Bits the host should see on TDO, given IR, scan length and data in.
    function automatic logic [31:0] exp_dr(input logic [4:0] ir, input int n,
                                           input logic [31:0] din, input logic [31:0] cap);
        case (ir)
            5'b00010:                   return IDV & mask(n);
            5'b00100, 5'b00101, 5'b00110: return cap & mask(n);
            default:                    return (din << 1) & mask(n);
        endcase
    endfunction

    function automatic logic [2:0] exp_sel(input logic [4:0] ir);
        return {ir == 5'b00110, ir == 5'b00101, ir == 5'b00100};
    endfunction

    // One TCK: drive TMS/TDI, sample TDO and strobes before the rising edge.
    task automatic tick(input logic t, input logic d, output logic o);
        tms = t;
        tdi = d;
        #1;
        o = td_o;
        if (scan_in_o !== d) scan_bad++;
        if (capture_dr_o) cnt_cap++;
        if (shift_dr_o)   cnt_shift++;
        if (update_dr_o)  cnt_upd++;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // From RTI: IR scan of code, back to RTI; returns captured IR bits.
    task automatic ir_scan(input logic [4:0] code, input bit via_pause, output logic [4:0] cap);
        logic o;
        cap = '0;
        tick(1'b1, 1'b0, o);
        tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
        tick(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, code[i], o);
            cap[i] = o;
        end
        if (via_pause) begin
            tick(1'b0, 1'b0, o);
            tick(1'b0, 1'b0, o);
            tick(1'b1, 1'b0, o);
            tick(1'b1, 1'b0, o);
        end else begin
            tick(1'b1, 1'b0, o);
        end
        tick(1'b0, 1'b0, o);
    endtask

    // From RTI: DR scan of n bits, optional pause after bit pause_at.
    task automatic dr_scan(input int n, input logic [31:0] din, input int pause_at,
                           output logic [31:0] dout);
        logic o;
        dout = '0;
        cnt_cap = 0; cnt_shift = 0; cnt_upd = 0; scan_bad = 0;
        tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
        tick(1'b0, 1'b0, o);
        for (int i = 0; i < n; i++) begin
            tick((i == n - 1) || (i == pause_at), din[i], o);
            dout[i] = o;
            if (i == pause_at && i != n - 1) begin
                tick(1'b0, 1'b0, o);
                tick(1'b0, 1'b0, o);
                tick(1'b1, 1'b0, o);
                tick(1'b0, 1'b0, o);
            end
        end
        tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
        chk("dr_capture_cnt", 32'(cnt_cap), 32'd1);
        chk("dr_shift_cnt", 32'(cnt_shift), 32'(n));
        chk("dr_update_cnt", 32'(cnt_upd), 32'd1);
        chk("scan_in", 32'(scan_bad), 32'd0);
    endtask

    task automatic reg_test(input logic [4:0] code, input int n, input logic [31:0] cap,
                            input logic [31:0] din, input int pause_at, input bit ir_pause);
        logic [4:0]  ircap;
        logic [31:0] dout;
        ir_scan(code, ir_pause, ircap);
        chk("ir_capture", 32'(ircap), 32'h1);
        chk("sel", 32'({confreg_sel_o, fifo_sel_o, memory_sel_o}), 32'(exp_sel(code)));
        mem_cap  = cap[9:0];
        fifo_cap = cap[10:0];
        conf_cap = cap[11:0];
        dr_scan(n, din, pause_at, dout);
        chk("dr_tdo", dout, exp_dr(code, n, din, cap));
        if (code == 5'b00100) chk("mem_contents", 32'(r_mem), din & mask(n));
        if (code == 5'b00101) chk("fifo_contents", 32'(r_fifo), din & mask(n));
        if (code == 5'b00110) chk("conf_contents", 32'(r_conf), din & mask(n));
    endtask

    // Walk-model state ids (bench-local numbering)
    localparam int W_RESET = 0, W_IDLE = 1, W_DSEL = 2, W_DCAP = 3, W_DSH = 4,
                   W_DX1 = 5, W_DP = 6, W_DX2 = 7, W_DUP = 8, W_ISEL = 9,
                   W_ICAP = 10, W_ISH = 11, W_IX1 = 12, W_IP = 13, W_IX2 = 14, W_IUP = 15;

    function automatic int m_next(input int s, input logic t);
        case (s)
            W_RESET:        return t ? W_RESET : W_IDLE;
            W_IDLE:         return t ? W_DSEL  : W_IDLE;
            W_DSEL:         return t ? W_ISEL  : W_DCAP;
            W_ISEL:         return t ? W_RESET : W_ICAP;
            W_DCAP, W_DSH:  return t ? W_DX1   : W_DSH;
            W_ICAP, W_ISH:  return t ? W_IX1   : W_ISH;
            W_DX1:          return t ? W_DUP   : W_DP;
            W_IX1:          return t ? W_IUP   : W_IP;
            W_DP:           return t ? W_DX2   : W_DP;
            W_IP:           return t ? W_IX2   : W_IP;
            W_DX2:          return t ? W_DUP   : W_DSH;
            W_IX2:          return t ? W_IUP   : W_ISH;
            default:        return t ? W_DSEL  : W_IDLE;
        endcase
    endfunction

    initial begin
        logic        o, t, d;
        logic [4:0]  ircap, mir, msr;
        logic [31:0] dout, din, cap;
        int          s, n, sel;

        @(negedge tck);
        #1;
        // reset
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, o);
        chk("reset_tdo", 32'(td_o), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
        chk("reset_ir", 32'(dut.r_ir), 32'h02);
        chk("reset_sel", 32'({confreg_sel_o, fifo_sel_o, memory_sel_o}), 32'd0);
        chk("reset_strobes", 32'({capture_dr_o, shift_dr_o, update_dr_o}), 32'd0);
        chk("reset_tdo_rti", 32'(td_o), 32'd0);

        // IDCODE straight from reset
        dr_scan(32, 32'h0, -1, dout);
        chk("idcode_read", dout, IDV);
        din = $urandom;
        dr_scan(32, din, int'($urandom_range(0, 30)), dout);
        chk("idcode_pause", dout, IDV);

        // user registers
        reg_test(5'b00100, 10, 32'h0AB, 32'h011, -1, 1'b1);
        reg_test(5'b00101, 11, 32'h0CD, 32'h5A5, 4, 1'b0);
        reg_test(5'b00110, 12, 32'h0EF, 32'hC3C, -1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            sel = int'($urandom_range(0, 2));
            n   = 10 + sel;
            cap = $urandom & mask(n);
            din = $urandom & mask(n);
            reg_test(5'(5'd4 + sel), n, cap, din, int'($urandom_range(0, 12)) - 1, k[0]);
        end

        // bypass: send 1,0,1,1 -> see 0,1,0,1
        reg_test(5'b11111, 4, 32'h0, 32'hD, -1, 1'b0);
        reg_test(5'b00111, 4, 32'h0, 32'hD, -1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            do ircap = 5'($urandom_range(0, 31));
            while (ircap == 5'd2 || ircap == 5'd4 || ircap == 5'd5 || ircap == 5'd6);
            n = int'($urandom_range(2, 20));
            reg_test(ircap, n, 32'h0, $urandom & mask(n), int'($urandom_range(0, 20)) - 1, k[0]);
        end

        // IR capture with zeros shifted in
        ir_scan(5'b00000, 1'b0, ircap);
        chk("ir_capture_zero", 32'(ircap), 32'h1);

        // five TMS=1 reach TLR and reload IDCODE
        ir_scan(5'b00101, 1'b0, ircap);
        chk("pre_tlr_sel", 32'(fifo_sel_o), 32'd1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, o);
        chk("tlr_ir", 32'(dut.r_ir), 32'h02);
        chk("tlr_sel", 32'({confreg_sel_o, fifo_sel_o, memory_sel_o}), 32'd0);
        tick(1'b0, 1'b0, o);

        // reset in the middle of a REG1 shift
        ir_scan(5'b00100, 1'b0, ircap);
        tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
        tick(1'b0, 1'b0, o);
        tick(1'b0, 1'b1, o);
        tick(1'b0, 1'b0, o);
        chk("mid_shift", 32'({shift_dr_o, memory_sel_o}), 32'h3);
        rst_n = 1'b0;
        tick(1'b0, 1'b1, o);
        chk("midrst_ir", 32'(dut.r_ir), 32'h02);
        chk("midrst_sel", 32'(memory_sel_o), 32'd0);
        chk("midrst_strobes", 32'({capture_dr_o, shift_dr_o, update_dr_o}), 32'd0);
        chk("midrst_tdo", 32'(td_o), 32'd0);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, o);
        chk("midrst_tlr_hold", 32'({capture_dr_o, shift_dr_o, update_dr_o}), 32'd0);
        tick(1'b0, 1'b0, o);
        dr_scan(32, $urandom, -1, dout);
        chk("midrst_idcode", dout, IDV);

        // random TMS walk against a behavioural state/IR model
        s = W_IDLE;
        mir = 5'b00010;
        msr = 5'b00001;
        for (int k = 0; k < 400; k++) begin
            t = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            chk("walk_strobes", 32'({capture_dr_o, shift_dr_o, update_dr_o}),
                32'({s == W_DCAP, s == W_DSH, s == W_DUP}));
            chk("walk_sel", 32'({confreg_sel_o, fifo_sel_o, memory_sel_o}), 32'(exp_sel(mir)));
            if (s == W_ISH)      chk("walk_tdo_ir", 32'(td_o), 32'(msr[0]));
            else if (s != W_DSH) chk("walk_tdo_idle", 32'(td_o), 32'd0);
            tick(t, d, o);
            if (s == W_ICAP)     msr = 5'b00001;
            else if (s == W_ISH) msr = {d, msr[4:1]};
            else if (s == W_IUP) mir = msr;
            s = m_next(s, t);
            if (s == W_RESET) mir = 5'b00010;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1 TAP controller with a 5-bit instruction register, an internal IDCODE register and an internal BYPASS register.
It decodes the current instruction into select lines for three external user data registers: memory, fifo and confreg.
It broadcasts the DR state strobes and TDI to those registers and multiplexes their serial outputs onto TDO.
It sits between the chip JTAG pins and the scan-chain data-register cells.

Parameters:
IR_LEN, 5, instruction register width (fixed; the opcodes below assume 5).
IDCODE_VALUE, 32'h249511C3, value loaded into the IDCODE register in Capture-DR; bit 0 must be 1.

Ports:
tck_i  in  1  JTAG TCK; the single clock.
rst_ni  in  1  reset; synchronous, active-low.
tms_i  in  1  JTAG TMS, sampled on rising tck_i.
td_i  in  1  JTAG TDI.
td_o  out  1  JTAG TDO, registered on falling tck_i.
shift_dr_o  out  1  high while the FSM is in Shift-DR.
update_dr_o  out  1  high while the FSM is in Update-DR.
capture_dr_o  out  1  high while the FSM is in Capture-DR.
memory_sel_o  out  1  high when IR = REG1 (5'b00100).
fifo_sel_o  out  1  high when IR = REG2 (5'b00101).
confreg_sel_o  out  1  high when IR = REG3 (5'b00110).
scan_in_o  out  1  serial data toward the user registers; equals td_i combinationally.
memory_out_i  in  1  serial out of the memory register.
fifo_out_i  in  1  serial out of the fifo register.
confreg_out_i  in  1  serial out of the confreg register.

Behaviour:
- Opcodes: IDCODE 5'b00010, REG1 5'b00100, REG2 5'b00101, REG3 5'b00110, BYPASS 5'b11111. Every other code, including 00111/01000/01001, behaves as BYPASS.
- FSM: the standard 16 states, with transitions on rising tck_i driven by tms_i:
  - TLR: tms=1 stays, tms=0 goes to RTI.
  - RTI: tms=1 goes to SelDR.
  - SelDR: tms=0 goes to CapDR, tms=1 goes to SelIR.
  - SelIR: tms=0 goes to CapIR, tms=1 goes to TLR.
  - Capture: tms=0 goes to Shift, tms=1 goes to Exit1.
  - Shift: tms=1 goes to Exit1.
  - Exit1: tms=0 goes to Pause, tms=1 goes to Update.
  - Pause: tms=1 goes to Exit2.
  - Exit2: tms=0 goes to Shift, tms=1 goes to Update.
  - Update: tms=0 goes to RTI, tms=1 goes to SelDR.
- Reset: rst_ni low at rising tck_i forces the following; reset overrides everything, including mid-shift:
  - state = TLR;
  - IR = IDCODE;
  - IR shift register = 0;
  - IDCODE shift register = IDCODE_VALUE;
  - bypass = 0.
- td_o is cleared at the next falling tck_i while rst_ni is low.
- Entering TLR by any means reloads IR = IDCODE. Five TCKs with tms=1 reach TLR from any state.
- IR path, all actions on rising tck_i in the named state:
  - CapIR loads the shift register with 5'b00001.
  - ShiftIR shifts right: {td_i, sr[4:1]}.
  - UpdIR copies the shift register to IR.
  - IR is unchanged elsewhere.
- IDCODE register (32 bits):
  - CapDR with IR=IDCODE loads IDCODE_VALUE.
  - ShiftDR with IR=IDCODE shifts right, td_i into bit 31.
- Bypass register (1 bit): CapDR loads 0; ShiftDR loads td_i; both apply only when the bypass decode is active.
- Strobes and selects:
  - shift_dr_o, capture_dr_o and update_dr_o are pure state decodes, independent of IR.
  - The three sel outputs are pure IR decodes, independent of state.
  - All of these are combinational.
- TDO mux, sampled into the td_o flop on falling tck_i:
  - ShiftIR: IR shift register bit 0.
  - ShiftDR with IDCODE: IDCODE shift register bit 0.
  - ShiftDR with REG1/REG2/REG3: memory_out_i / fifo_out_i / confreg_out_i.
  - ShiftDR with any other IR: bypass bit.
  - Any other state: 0.
- Timing: with a capture at the rising edge that enters Shift, bit 0 of the captured data is on td_o after the next falling edge. The host samples that bit just before the following rising edge. N shifting edges (the last leaving Shift via Exit1) transfer exactly N bits.
- Pause/Exit2/re-enter Shift preserves all shift contents.

Decomposition:
- Package jtag_tap_pkg:
  - tap state enum (16 states);
  - IR_LEN;
  - opcode localparams: IDCODE, REG1, REG2, REG3, BYPASS;
  - CAPTURE_IR pattern.
- One natural sub-module: jtag_tap_fsm (state register plus next-state logic and state decode strobes). IR, IDCODE, bypass and the TDO mux stay in the top.

Test Plan:
- Reset: hold rst_ni=0 for 3 TCKs, release, then 5 TCKs tms=1 and 1 TCK tms=0 → state RTI; IR=00010; all sel=0; td_o=0.
- IDCODE read: from reset go to ShiftDR, shift 32 bits of 0 → TDO stream LSB-first equals 32'h249511C3.
- REG1 select: shift IR 5'b00100 via Shift-Exit1-Pause-Exit2-Update → memory_sel_o=1, others 0. A bench 10-bit register capturing 10'h0AB, shifted with td_i=10'h011, returns 10'h0AB on TDO; update_dr_o pulses for exactly one TCK.
- REG2/REG3: IR 00101 / 00110 with 11-bit 'hCD and 12-bit 'hEF bench registers → TDO returns 'hCD and 'hEF; scan_in_o tracks td_i.
- Bypass: IR=11111 (and IR=00111), shift pattern 1011 → TDO shows 0 then 1,0,1 (one-bit delay); all sel=0.
- IR capture and reset mid-shift: ShiftIR of 5 zeros returns 5'b00001. Asserting rst_ni mid-ShiftDR gives TLR with IR=IDCODE on the next rising edge.
